// File: rtl/alu_seq_pkg.sv
// Shared opcodes, iterative-unit modes and FSM encoding for the sequential ALU.
// Op 7 (OP_REM) is only a real operation when ALU_SEQ_REM_EN is defined.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_REM = 3'd7;

    localparam logic MD_MUL = 1'b0;
    localparam logic MD_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one step per enabled cycle.
// The rem_o port exists only when ALU_SEQ_REM_EN is defined.
module alu_iter_muldiv
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      start_i,
    input  logic                      mode_i,
    input  logic [DATA_WIDTH-1:0]     a_i,
    input  logic [DATA_WIDTH-1:0]     b_i,
    output logic                      done_o,
    output logic [DATA_WIDTH-1:0]     quot_o,
`ifdef ALU_SEQ_REM_EN
    output logic [DATA_WIDTH-1:0]     rem_o,
`endif
    output logic [2*DATA_WIDTH-1:0]   prod_o
);

    logic                  run_q;
    logic                  mode_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] opnd_q;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH:0]   diff;
    logic                  last;

    // hi/lo hold {product high, multiplier} for MUL and {remainder, quotient} for DIV
    assign sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign trial = {hi_q, lo_q[DATA_WIDTH-1]};
    assign diff  = trial - {1'b0, opnd_q};

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (mode_q == MD_MUL) begin
            hi_d = sum[DATA_WIDTH:1];
            lo_d = {sum[0], lo_q[DATA_WIDTH-1:1]};
        end else if (trial >= {1'b0, opnd_q}) begin
            hi_d = diff[DATA_WIDTH-1:0];
            lo_d = {lo_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
            hi_d = trial[DATA_WIDTH-1:0];
            lo_d = {lo_q[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // Results are the post-step values, so the caller can capture them on the final step
    assign last   = run_q && (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));
    assign done_o = last;
    assign quot_o = lo_d;
`ifdef ALU_SEQ_REM_EN
    assign rem_o  = hi_d;
`endif
    assign prod_o = {hi_d, lo_d};

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (enable) begin
            if (start_i) begin
                run_q <= 1'b1;
                cnt_q <= '0;
            end else if (run_q) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
                if (last) begin
                    run_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enable) begin
            if (start_i) begin
                mode_q <= mode_i;
                hi_q   <= '0;
                lo_q   <= (mode_i == MD_MUL) ? b_i : a_i;
                opnd_q <= (mode_i == MD_MUL) ? a_i : b_i;
            end else if (run_q) begin
                hi_q <= hi_d;
                lo_q <= lo_d;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: one op in flight, valid/ready on both sides, iterative MUL/DIV.
// Define ALU_SEQ_REM_EN to make op 7 an unsigned remainder on the divider path.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int DATA_WIDTH   = 8,
    parameter  int OPCODE_WIDTH = 3,
    localparam int CNT_WIDTH    = $clog2(DATA_WIDTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPCODE_WIDTH-1:0] op_code,
    input  logic [DATA_WIDTH-1:0]   op0,
    input  logic [DATA_WIDTH-1:0]   op1,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out,
    output logic                    flag_zero,
    output logic                    flag_carry,
    output logic                    flag_ovf
);

    state_t                    state_q, state_d;
    logic [OPCODE_WIDTH-1:0]   op_q;
    logic [DATA_WIDTH-1:0]     out_q;
    logic                      zero_q, carry_q, ovf_q;

    logic                      accept;
    logic                      op1_zero;
    logic                      is_iter;
    logic [DATA_WIDTH:0]       add_w, sub_w;
    logic [DATA_WIDTH-1:0]     sc_res, it_res;
    logic                      sc_carry, sc_ovf, it_ovf;

    logic                      it_done;
    logic [DATA_WIDTH-1:0]     it_quot;
    logic [2*DATA_WIDTH-1:0]   it_prod;
`ifdef ALU_SEQ_REM_EN
    logic [DATA_WIDTH-1:0]     it_rem;
`endif

    assign accept   = in_valid && in_ready && enable;
    assign op1_zero = (op1 == '0);
    assign add_w    = {1'b0, op0} + {1'b0, op1};
    assign sub_w    = {1'b0, op0} - {1'b0, op1};

    alu_iter_muldiv #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .start_i (accept && is_iter),
        .mode_i  ((op_code == OP_MUL) ? MD_MUL : MD_DIV),
        .a_i     (op0),
        .b_i     (op1),
        .done_o  (it_done),
        .quot_o  (it_quot),
`ifdef ALU_SEQ_REM_EN
        .rem_o   (it_rem),
`endif
        .prod_o  (it_prod)
    );

    // Division by zero never enters BUSY; it resolves in the single-cycle path
    always_comb begin
        is_iter  = 1'b0;
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        case (op_code)
            OP_ADD: begin sc_res = add_w[DATA_WIDTH-1:0]; sc_carry = add_w[DATA_WIDTH]; end
            OP_SUB: begin sc_res = sub_w[DATA_WIDTH-1:0]; sc_carry = sub_w[DATA_WIDTH]; end
            OP_MUL: is_iter = 1'b1;
            OP_DIV: begin is_iter = !op1_zero; sc_res = '1; sc_ovf = 1'b1; end
            OP_AND: sc_res = op0 & op1;
            OP_OR:  sc_res = op0 | op1;
            OP_XOR: sc_res = op0 ^ op1;
`ifdef ALU_SEQ_REM_EN
            OP_REM: begin is_iter = !op1_zero; sc_res = op0; sc_ovf = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        it_res = it_quot;
        it_ovf = 1'b0;
        if (op_q == OP_MUL) begin
            it_res = it_prod[DATA_WIDTH-1:0];
            it_ovf = |it_prod[2*DATA_WIDTH-1:DATA_WIDTH];
        end
`ifdef ALU_SEQ_REM_EN
        else if (op_q == OP_REM) begin
            it_res = it_rem;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = is_iter ? BUSY : DONE;
            BUSY:    if (it_done) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (enable) begin
            if (accept && !is_iter) begin
                out_q   <= sc_res;
                zero_q  <= (sc_res == '0);
                carry_q <= sc_carry;
                ovf_q   <= sc_ovf;
            end else if ((state_q == BUSY) && it_done) begin
                out_q   <= it_res;
                zero_q  <= (it_res == '0);
                carry_q <= 1'b0;
                ovf_q   <= it_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= op_code;
        end
    end

    assign out        = out_q;
    assign flag_zero  = zero_q;
    assign flag_carry = carry_q;
    assign flag_ovf   = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at DATA_WIDTH=8; op 7 expectations follow ALU_SEQ_REM_EN.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, enable, in_valid, in_ready, out_valid, out_ready;
    logic         flag_zero, flag_carry, flag_ovf;
    logic [2:0]   op_code;
    logic [W-1:0] op0, op1, out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_seq #(.DATA_WIDTH(W), .OPCODE_WIDTH(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_code    (op_code),
        .op0        (op0),
        .op1        (op1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_ovf   (flag_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single edge, then scramble the inputs
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        op_code  = op;
        op0      = a;
        op1      = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        op_code  = 3'd0;
        op0      = ~a;
        op1      = ~b;
    endtask

    task automatic wait_valid(inout int cyc, inout logic rdy_seen);
        while (!out_valid && cyc < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            step();
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int e_out, input int e_c,
                          input int e_o, input int e_z, input int e_lat);
        int   cyc;
        logic rdy_seen;
        cyc      = 1;
        rdy_seen = 1'b0;
        issue(op, a, b);
        wait_valid(cyc, rdy_seen);
        check({tag, "/lat"},   cyc, e_lat);
        check({tag, "/out"},   out, e_out);
        check({tag, "/carry"}, flag_carry, e_c);
        check({tag, "/ovf"},   flag_ovf, e_o);
        check({tag, "/zero"},  flag_zero, e_z);
        if (e_lat > 1) check({tag, "/busy_rdy"}, rdy_seen, 0);
        step();
        check({tag, "/idle"}, in_ready, 1);
    endtask

    initial begin
        int   cyc;
        logic rdy_seen;
        logic stable;

        reset     = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_code   = 3'd0;
        op0       = '0;
        op1       = '0;
        step();
        step();
        reset = 1'b0;
        check("rst/out_valid", out_valid, 0);
        check("rst/in_ready",  in_ready, 1);
        check("rst/out",       out, 0);
        check("rst/flags",     {flag_zero, flag_carry, flag_ovf}, 0);

        run_op("add200_100", 3'd0, 8'd200, 8'd100, 44,  1, 0, 0, 1);
        run_op("sub5_5",     3'd1, 8'd5,   8'd5,   0,   0, 0, 1, 1);
        run_op("sub3_5",     3'd1, 8'd3,   8'd5,   254, 1, 0, 0, 1);
        run_op("and",        3'd4, 8'hF0,  8'h3C,  48,  0, 0, 0, 1);
        run_op("or",         3'd5, 8'hF0,  8'h0C,  252, 0, 0, 0, 1);
        run_op("xor",        3'd6, 8'hAA,  8'hAA,  0,   0, 0, 1, 1);
        run_op("mul20_13",   3'd2, 8'd20,  8'd13,  4,   0, 1, 0, 9);
        run_op("mul7_9",     3'd2, 8'd7,   8'd9,   63,  0, 0, 0, 9);
        run_op("mul255_255", 3'd2, 8'd255, 8'd255, 1,   0, 1, 0, 9);
        run_op("div100_7",   3'd3, 8'd100, 8'd7,   14,  0, 0, 0, 9);
        run_op("div255_16",  3'd3, 8'd255, 8'd16,  15,  0, 0, 0, 9);
        run_op("div9_0",     3'd3, 8'd9,   8'd0,   255, 0, 1, 0, 1);
`ifdef ALU_SEQ_REM_EN
        run_op("rem100_7",   3'd7, 8'd100, 8'd7,   2,   0, 0, 0, 9);
        run_op("rem9_0",     3'd7, 8'd9,   8'd0,   9,   0, 1, 0, 1);
`else
        run_op("op7",        3'd7, 8'd100, 8'd7,   0,   0, 0, 1, 1);
`endif

        // enable low must block acceptance while in_ready stays high
        enable   = 1'b0;
        op_code  = 3'd0;
        op0      = 8'd1;
        op1      = 8'd2;
        in_valid = 1'b1;
        step();
        check("en_gate/out_valid", out_valid, 0);
        check("en_gate/in_ready",  in_ready, 1);
        in_valid = 1'b0;
        enable   = 1'b1;

        // backpressure in DONE, with a competing request that must be ignored
        out_ready = 1'b0;
        issue(3'd0, 8'd10, 8'd20);
        check("bp/out_valid", out_valid, 1);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            op_code  = 3'd0;
            op0      = 8'd1;
            op1      = 8'd1;
            in_valid = 1'b1;
            step();
            if (out !== 8'd30 || out_valid !== 1'b1 || in_ready !== 1'b0 ||
                flag_zero !== 1'b0 || flag_carry !== 1'b0 || flag_ovf !== 1'b0)
                stable = 1'b0;
        end
        in_valid = 1'b0;
        check("bp/stable", stable, 1);
        out_ready = 1'b1;
        step();
        check("bp/released", out_valid, 0);
        check("bp/in_ready", in_ready, 1);

        // 3-cycle enable drop mid-BUSY
        cyc      = 1;
        rdy_seen = 1'b0;
        issue(3'd2, 8'd7, 8'd9);
        repeat (3) begin step(); cyc++; end
        enable = 1'b0;
        repeat (3) begin step(); cyc++; end
        enable = 1'b1;
        wait_valid(cyc, rdy_seen);
        check("en_stall/lat", cyc, 12);
        check("en_stall/out", out, 63);
        check("en_stall/ovf", flag_ovf, 0);
        step();

        // reset in the middle of a MUL
        issue(3'd2, 8'd20, 8'd13);
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mul/out_valid", out_valid, 0);
        check("rst_mul/out",       out, 0);
        check("rst_mul/in_ready",  in_ready, 1);
        check("rst_mul/ovf",       flag_ovf, 0);
        stable = 1'b1;
        repeat (10) begin
            step();
            if (out_valid !== 1'b0) stable = 1'b0;
        end
        check("rst_mul/no_resume", stable, 1);
        run_op("add1_1", 3'd0, 8'd1, 8'd1, 2, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
